// File: rtl/draw_lives_if.sv
// draw_lives_if: pixel stream bundle (counters, sync/blank strobes, colour)
interface draw_lives_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;
   modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_lives.sv
// draw_lives: overlays heart sprites for the remaining lives, blinking the last lost one
module draw_lives #(
   parameter int          XPOS         = 16,
   parameter int          YPOS         = 16,
   parameter int          SPACING      = 32,
   parameter int          MAX_LIVES    = 3,
   parameter int          BLINK_FRAMES = 64,
   parameter logic [11:0] TRANSPARENT  = 12'h000
) (
   input  logic         clk,
   input  logic         rst,
   draw_lives_if.slave  vin,
   draw_lives_if.master vout,
   input  logic [2:0]   lives_in,
   output logic [9:0]   rom_addr,
   input  logic [11:0]  rom_rgb
);
   typedef enum logic {IDLE, BLINK} state_t;
   typedef struct packed {
      logic [10:0] hc;
      logic [10:0] vc;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
   } pix_t;
   state_t      state, state_n;
   logic [2:0]  lives_disp, lives_n, lives_c;
   logic [7:0]  blink_cnt, cnt_n;
   logic        frame, vis;
   pix_t        s0, s1, s2, s3;
   logic        hit_c, hit1, hit2;
   logic [2:0]  slot_c, slot1, slot2;
   logic [9:0]  addr_c;
   logic signed [31:0] dx, dy;
   assign s0 = {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.rgb};
   assign {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb} = s3;
   assign lives_c = (lives_in > 3'(MAX_LIVES)) ? 3'(MAX_LIVES) : lives_in;
   assign frame = vin.vblnk & ~s1.vb;
   assign vis = (slot2 < lives_disp) || (state == BLINK && slot2 == lives_disp && blink_cnt[3]);
   // locate the heart slot under the incoming pixel; slots never overlap since the pitch exceeds the width
   always_comb begin
      hit_c = 1'b0;
      slot_c = 3'd0;
      addr_c = 10'd0;
      dx = 32'sd0;
      dy = 32'(signed'({21'd0, vin.vcount})) - YPOS;
      for (int k = 0; k < MAX_LIVES; k++) begin
         dx = 32'(signed'({21'd0, vin.hcount})) - XPOS - k * SPACING;
         if (dx >= 0 && dx < 29 && dy >= 0 && dy < 31) begin
            hit_c = 1'b1;
            slot_c = 3'(k);
            addr_c = {dy[4:0], dx[4:0]};
         end
      end
   end
   // lives / blink state advances only on the rising edge of vertical blanking
   always_comb begin
      state_n = state;
      lives_n = lives_disp;
      cnt_n = blink_cnt;
      if (frame) begin
         if (lives_c < lives_disp) begin
            lives_n = lives_c;
            cnt_n = 8'(BLINK_FRAMES);
            state_n = BLINK;
         end else if (state == IDLE || lives_c > lives_disp) begin
            lives_n = lives_c;
            state_n = IDLE;
         end else begin
            cnt_n = blink_cnt - 8'd1;
            state_n = (blink_cnt == 8'd1) ? IDLE : BLINK;
         end
      end
   end
   // FSM and displayed-lives registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         lives_disp <= 3'(MAX_LIVES);
         blink_cnt <= 8'd0;
      end else begin
         state <= state_n;
         lives_disp <= lives_n;
         blink_cnt <= cnt_n;
      end
   end
   // three-stage pixel pipeline: address, ROM wait, colour select
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr <= 10'd0;
         hit1 <= 1'b0;
         hit2 <= 1'b0;
         slot1 <= 3'd0;
         slot2 <= 3'd0;
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         rom_addr <= addr_c;
         hit1 <= hit_c;
         slot1 <= slot_c;
         s1 <= s0;
         hit2 <= hit1;
         slot2 <= slot1;
         s2 <= s1;
         s3 <= s2;
         s3.rgb <= (hit2 && vis && rom_rgb != TRANSPARENT) ? rom_rgb : s2.rgb;
      end
   end
endmodule

// File: tb/tb_draw_lives.sv
// tb_draw_lives: directed table, blink sequences and randomized frames against a lives model
module tb_draw_lives;
   localparam int XP = 16, YP = 16, SP = 32, ML = 3, BF = 64;
   localparam logic [11:0] TR = 12'h000;
   typedef struct packed {
      logic [10:0] hc;
      logic [10:0] vc;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
      logic [9:0]  addr;
   } exp_t;
   typedef struct {
      int          hc;
      int          vc;
      logic [11:0] rgb;
      logic [9:0]  addr;
      logic [11:0] out;
   } vec_t;
   logic clk = 1'b0;
   logic rst;
   logic [2:0] lives_in;
   logic [9:0] rom_addr;
   logic [11:0] rom_rgb;
   draw_lives_if vin();
   draw_lives_if vout();
   exp_t pipe[3];
   vec_t tbl[10];
   int errs = 0, checks = 0;
   int ld, left;
   bit blinking, prev_vb;
   always #5 clk = ~clk;
   draw_lives #(.XPOS(XP), .YPOS(YP), .SPACING(SP), .MAX_LIVES(ML), .BLINK_FRAMES(BF), .TRANSPARENT(TR)) dut (
      .clk(clk), .rst(rst), .vin(vin), .vout(vout),
      .lives_in(lives_in), .rom_addr(rom_addr), .rom_rgb(rom_rgb));
   function automatic logic [11:0] rom_f(input logic [9:0] a);
      return (a == 10'd0) ? 12'hF00 : (a[2:0] == 3'd5) ? 12'h000 : 12'(a * 13 + 1);
   endfunction
   always @(posedge clk) rom_rgb <= rom_f(rom_addr);
   function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endfunction
   function automatic void frame_update();
      int lc;
      lc = (int'(lives_in) > ML) ? ML : int'(lives_in);
      if (lc < ld) begin
         ld = lc;
         left = BF;
         blinking = 1;
      end else if (!blinking || lc > ld) begin
         ld = lc;
         blinking = 0;
      end else begin
         left = left - 1;
         if (left == 0) blinking = 0;
      end
   endfunction
   function automatic void model_px(input int hc, input int vc, input logic [11:0] rgb,
                                    output logic [9:0] a, output logic [11:0] o);
      int dx, dy, k;
      dx = hc - XP;
      dy = vc - YP;
      a = 10'd0;
      o = rgb;
      if (dx >= 0 && dx / SP < ML && dx % SP < 29 && dy >= 0 && dy < 31) begin
         k = dx / SP;
         a = 10'((dy % 32) * 32 + (dx % SP) % 32);
         if ((k < ld || (blinking && k == ld && (left / 8) % 2 == 1)) && rom_f(a) != TR) o = rom_f(a);
      end
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
      chk("rom_addr", 64'(rom_addr), 64'(pipe[0].addr));
      chk("rgb_out", 64'(vout.rgb), 64'(pipe[2].rgb));
      chk("timing", 64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}),
          64'({pipe[2].hc, pipe[2].vc, pipe[2].hs, pipe[2].vs, pipe[2].hb, pipe[2].vb}));
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
   endtask
   task automatic drive(input int hc, input int vc, input logic vb, input logic [11:0] rgb,
                        input logic [11:0] er, input logic [9:0] ea);
      exp_t e;
      tick();
      e.hc = 11'(hc);
      e.vc = 11'(vc);
      e.hs = 1'($urandom);
      e.vs = 1'($urandom);
      e.hb = 1'($urandom);
      e.vb = vb;
      e.rgb = er;
      e.addr = ea;
      vin.hcount = e.hc;
      vin.vcount = e.vc;
      vin.hsync = e.hs;
      vin.vsync = e.vs;
      vin.hblnk = e.hb;
      vin.vblnk = vb;
      vin.rgb = rgb;
      if (vb && !prev_vb) frame_update();
      prev_vb = vb;
      pipe[0] = e;
   endtask
   task automatic px(input int hc, input int vc);
      logic [11:0] r, o;
      logic [9:0] a;
      r = 12'($urandom);
      model_px(hc, vc, r, a, o);
      drive(hc, vc, 1'b0, r, o, a);
   endtask
   task automatic vec(input int hc, input int vc, input logic [11:0] r, input logic [11:0] o);
      drive(hc, vc, 1'b0, r, o, 10'd0);
   endtask
   task automatic frame_end();
      logic [11:0] r;
      for (int i = 0; i < 5; i++) begin
         r = 12'($urandom);
         drive(1000, 1000, i >= 2, r, r, 10'd0);
      end
   endtask
   task automatic rand_frame(input int n, input bit new_lives);
      for (int k = 0; k <= ML; k++) px(XP + k * SP + int'($urandom_range(0, 28)), YP + int'($urandom_range(0, 30)));
      for (int i = 0; i < n; i++) begin
         if (new_lives && $urandom_range(0, 3) == 0) lives_in = 3'($urandom);
         px(XP + int'($urandom_range(0, 3)) * SP + int'($urandom_range(0, 33)) - 2, YP + int'($urandom_range(0, 33)) - 1);
      end
      frame_end();
   endtask
   task automatic zero_outputs(input string nm);
      chk({nm, "_rgb"}, 64'(vout.rgb), 64'd0);
      chk({nm, "_addr"}, 64'(rom_addr), 64'd0);
      chk({nm, "_timing"}, 64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}), 64'd0);
   endtask
   task automatic idle_inputs();
      vin.hcount = '0;
      vin.vcount = '0;
      vin.hsync = 1'b0;
      vin.vsync = 1'b0;
      vin.hblnk = 1'b0;
      vin.vblnk = 1'b0;
      vin.rgb = '0;
   endtask
   task automatic reset_mid();
      #2;
      rst = 1'b1;
      #1;
      zero_outputs("async_rst");
      idle_inputs();
      @(posedge clk);
      #1;
      zero_outputs("hold_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      ld = ML;
      left = 0;
      blinking = 0;
      prev_vb = 0;
   endtask
   initial begin
      tbl[0] = '{16, 16, 12'h123, 10'd0, 12'hF00};
      tbl[1] = '{50, 20, 12'h234, 10'd130, 12'h69B};
      tbl[2] = '{45, 20, 12'h456, 10'd0, 12'h456};
      tbl[3] = '{21, 16, 12'h0A0, 10'd5, 12'h0A0};
      tbl[4] = '{44, 46, 12'h567, 10'd988, 12'h22D};
      tbl[5] = '{16, 47, 12'h789, 10'd0, 12'h789};
      tbl[6] = '{15, 16, 12'hABC, 10'd0, 12'hABC};
      tbl[7] = '{80, 16, 12'h135, 10'd0, 12'hF00};
      tbl[8] = '{108, 46, 12'h246, 10'd988, 12'h22D};
      tbl[9] = '{112, 16, 12'h321, 10'd0, 12'h321};
      rst = 1'b1;
      lives_in = 3'd3;
      idle_inputs();
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      ld = ML;
      left = 0;
      blinking = 0;
      prev_vb = 0;
      #12;
      zero_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) drive(tbl[i].hc, tbl[i].vc, 1'b0, tbl[i].rgb, tbl[i].out, tbl[i].addr);
      lives_in = 3'd2;
      vec(80, 16, 12'h111, 12'hF00);
      frame_end();
      vec(80, 16, 12'h222, 12'h222);
      vec(48, 16, 12'h333, 12'hF00);
      frame_end();
      vec(80, 16, 12'h444, 12'hF00);
      for (int f = 0; f < 70; f++) rand_frame(4, 0);
      vec(80, 16, 12'h555, 12'h555);
      vec(48, 16, 12'h556, 12'hF00);
      lives_in = 3'd3;
      frame_end();
      lives_in = 3'd2;
      frame_end();
      frame_end();
      vec(80, 16, 12'h600, 12'hF00);
      lives_in = 3'd0;
      frame_end();
      vec(80, 16, 12'h666, 12'h666);
      vec(48, 16, 12'h777, 12'h777);
      vec(16, 16, 12'h888, 12'h888);
      frame_end();
      vec(16, 16, 12'h999, 12'hF00);
      vec(48, 16, 12'hAAA, 12'hAAA);
      vec(80, 16, 12'hAAB, 12'hAAB);
      lives_in = 3'd7;
      frame_end();
      vec(112, 16, 12'hBBB, 12'hBBB);
      vec(80, 16, 12'hCCC, 12'hF00);
      lives_in = 3'd1;
      frame_end();
      for (int f = 0; f < 3; f++) rand_frame(3, 0);
      reset_mid();
      vec(80, 16, 12'hDDD, 12'hF00);
      vec(16, 16, 12'hDDE, 12'hF00);
      for (int f = 0; f < 60; f++) begin
         lives_in = 3'($urandom);
         rand_frame(6, 1);
      end
      for (int i = 0; i < 3; i++) vec(1000, 1000, 12'h0F0, 12'h0F0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/draw_lives.md
DRAW_LIVES -- requirements
Module: draw_lives

Interface
REQ-001 Parameter XPOS, default 16: left edge (pixels) of heart 0.
REQ-002 Parameter YPOS, default 16: top edge (pixels) of all hearts.
REQ-003 Parameter SPACING, default 32: horizontal pitch between heart left edges; SHALL be >= 29.
REQ-004 Parameter MAX_LIVES, default 3: heart slots drawn, range 1..7.
REQ-005 Parameter BLINK_FRAMES, default 64: frames a lost heart blinks, range 1..255.
REQ-006 Parameter TRANSPARENT, default 12'h000: ROM colour treated as see-through.
REQ-007 clk  in  1  pixel clock; the block SHALL use this single clock only.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 hcount_in, vcount_in  in  11 each  pixel position of the incoming stream.
REQ-010 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  incoming timing strobes.
REQ-011 rgb_in  in  12  background pixel colour.
REQ-012 lives_in  in  3  current life count from game logic; values above MAX_LIVES clamp to MAX_LIVES.
REQ-013 rom_addr  out  10  heart ROM address {y[4:0], x[4:0]}, registered.
REQ-014 rom_rgb  in  12  heart ROM pixel, valid one clk after rom_addr.
REQ-015 hcount_out, vcount_out  out  11 each; hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each; rgb_out  out  12: delayed stream with hearts overlaid.

Function
REQ-016 Heart slot k (0..MAX_LIVES-1) region: XPOS+k*SPACING <= hcount_in < XPOS+k*SPACING+29 and YPOS <= vcount_in < YPOS+31.
REQ-017 Cycle 1: rom_addr SHALL register {(vcount_in-YPOS)[4:0], (hcount_in-XPOS-k*SPACING)[4:0]} for the slot containing the pixel, else 10'd0; the hit flag and slot index k SHALL be registered alongside.
REQ-018 Cycle 2: the ROM returns rom_rgb; the hit flag, slot index and rgb_in SHALL be delayed to align.
REQ-019 Cycle 3: rgb_out SHALL equal rom_rgb when hit, slot visible (REQ-022) and rom_rgb != TRANSPARENT; otherwise the delayed rgb_in.
REQ-020 All outputs other than rom_addr SHALL have exactly 3 clk latency; every timing and count output SHALL be the corresponding input delayed 3 clk, unmodified.
REQ-021 Frame boundary SHALL be the rising edge of vblnk_in (detected against its 1-clk delayed copy); lives_disp (3 bit) and FSM update only at a frame boundary.
REQ-022 Slot k visible when k < lives_disp, or when state = BLINK, k = lives_disp and blink_cnt[3] = 1.
REQ-023 FSM states IDLE, BLINK; blink_cnt 8 bit.
REQ-024 IDLE, boundary, clamped lives_in < lives_disp: lives_disp <= lives_in, blink_cnt <= BLINK_FRAMES, go to BLINK.
REQ-025 IDLE, boundary, clamped lives_in >= lives_disp: lives_disp <= clamped lives_in, stay IDLE.
REQ-026 BLINK, boundary: blink_cnt decrements; on reaching 0 go to IDLE; if clamped lives_in < lives_disp at the same boundary, lives_disp <= lives_in and blink_cnt reloads BLINK_FRAMES (restart blink on the new lost slot, previous slot stops drawing immediately).
REQ-027 BLINK, boundary, clamped lives_in > lives_disp: lives_disp <= lives_in, go to IDLE.
REQ-028 Lives drop of more than one in one frame: only slot lives_in blinks; higher slots disappear immediately.
REQ-029 lives_in changes between boundaries SHALL have no visible effect until the next boundary.

Reset
REQ-030 While rst is high: all outputs 0 (rgb_out 12'h000, rom_addr 10'd0), pipeline registers 0, state IDLE, blink_cnt 0, lives_disp MAX_LIVES.
REQ-031 rst asserted mid-frame or mid-BLINK SHALL take effect immediately; after release, the first 3 clk of outputs are 0 and the pipeline refills from fresh inputs.

Verification
REQ-032 Reset, lives_in=3, pixel (16,16) with rom_rgb=12'hF00 at the aligned cycle -> rom_addr=10'd0 after 1 clk; rgb_out=12'hF00 exactly 3 clk after input.
REQ-033 Pixel (50,20), slot 1 -> rom_addr={5'd4,5'd2}=10'd130; pixel (45,20) (gap) -> rgb_out=rgb_in delayed 3 clk, rom_addr=0.
REQ-034 rom_rgb=TRANSPARENT inside slot 0, rgb_in=12'h0A0 -> rgb_out=12'h0A0.
REQ-035 lives_in 3->2 mid-frame -> no change until vblnk_in rise; then slot 2 visible only in frames where blink_cnt[3]=1, gone after 64 frames, state IDLE.
REQ-036 During BLINK, lives_in 2->0 at a boundary -> slot 2 vanishes immediately, slot 0 blinks with blink_cnt=64, slot 1 never drawn.
REQ-037 lives_in=7 with MAX_LIVES=3 -> exactly 3 hearts; rst pulse mid-BLINK -> state IDLE, lives_disp=3, outputs 0 during reset.
